mem_port_arbiter: RTL and testbench

Clocked round-robin arbiter and sequencer that shares the single SNN memory port (read/write command, T/x/y address, write data, read data return) among `N_REQ` requesters such as PE clusters and the NOC wrapper. It accepts one transaction at a time, drives the memory command handshake, and routes read data back to the requester that issued the read. It sits between the requester-side interfaces and the memory block, and replaces ad-hoc direct wiring of a single client to memory.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/rr_arbiter.sv | 39 +++
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default widths for the SNN memory-port arbiter.
//   arb_state_t : sequencer state (IDLE, ISSUE, WAIT_RD, RESP)
//   T_W, XY_W, DATA_W : default timestep, coordinate and data widths
package mem_arb_pkg;

    localparam int unsigned T_W    = 4;
    localparam int unsigned XY_W   = 5;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        RESP
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: single SNN memory port (command + read-data return).
//   master : arbiter side, drives the command and mem_rd_ready
//   slave  : memory side, drives mem_cmd_ready and the read-data return
interface mem_port_arbiter_if #(
    parameter int unsigned T_W    = mem_arb_pkg::T_W,
    parameter int unsigned XY_W   = mem_arb_pkg::XY_W,
    parameter int unsigned DATA_W = mem_arb_pkg::DATA_W
);

    logic              mem_cmd_valid;
    logic              mem_cmd_ready;
    logic              mem_we;
    logic [T_W-1:0]    mem_t;
    logic [XY_W-1:0]   mem_x;
    logic [XY_W-1:0]   mem_y;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd_valid;
    logic              mem_rd_ready;
    logic [DATA_W-1:0] mem_rd_data;

    modport master (
        output mem_cmd_valid,
        input  mem_cmd_ready,
        output mem_we,
        output mem_t,
        output mem_x,
        output mem_y,
        output mem_wdata,
        input  mem_rd_valid,
        output mem_rd_ready,
        input  mem_rd_data
    );

    modport slave (
        input  mem_cmd_valid,
        output mem_cmd_ready,
        input  mem_we,
        input  mem_t,
        input  mem_x,
        input  mem_y,
        input  mem_wdata,
        output mem_rd_valid,
        input  mem_rd_ready,
        output mem_rd_data
    );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotate-priority pick.
//   req_valid : per-requester valid
//   rr_ptr    : highest-priority requester index this cycle
//   grant     : one-hot winner (zero when nothing is valid)
//   grant_idx : index of the winner
//   any_valid : at least one requester is valid
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_valid
);

    int unsigned idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        idx       = 0;
        // Walk N_REQ positions starting at rr_ptr; first valid one wins.
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!any_valid && req_valid[idx]) begin
                any_valid  = 1'b1;
                grant_idx  = IDX_W'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter and sequencer sharing one SNN memory port
// among N_REQ requesters, one transaction at a time.
//   clk, rst             : clock, synchronous active-high reset
//   req_valid/req_ready  : per-requester request handshake (ready is one-hot)
//   req_we/t/x/y/wdata   : packed per-requester command fields
//   rsp_valid/rsp_ready  : per-requester read-response handshake (valid is one-hot)
//   rsp_data             : shared read data, qualified by rsp_valid
//   mem                  : memory command and read-data port
//   busy                 : a transaction is in flight
//   grant_id             : index of the current or most recent grant
module mem_port_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned T_W    = mem_arb_pkg::T_W,
    parameter int unsigned XY_W   = mem_arb_pkg::XY_W,
    parameter int unsigned DATA_W = mem_arb_pkg::DATA_W,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ-1:0]        req_we,
    input  logic [N_REQ*T_W-1:0]    req_t,
    input  logic [N_REQ*XY_W-1:0]   req_x,
    input  logic [N_REQ*XY_W-1:0]   req_y,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        rsp_valid,
    input  logic [N_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]       rsp_data,
    mem_port_arbiter_if.master      mem,
    output logic                    busy,
    output logic [IDX_W-1:0]        grant_id
);

    import mem_arb_pkg::*;

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  grant_id_q, grant_id_d;
    logic              we_q, we_d;
    logic [T_W-1:0]    t_q, t_d;
    logic [XY_W-1:0]   x_q, x_d;
    logic [XY_W-1:0]   y_q, y_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic [N_REQ-1:0]  pick_grant;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any_valid (pick_any)
    );

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        we_d       = we_q;
        t_d        = t_q;
        x_d        = x_q;
        y_d        = y_q;
        wdata_d    = wdata_q;
        rsp_data_d = rsp_data_q;

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    we_d       = req_we[pick_idx];
                    t_d        = req_t[32'(pick_idx)*T_W +: T_W];
                    x_d        = req_x[32'(pick_idx)*XY_W +: XY_W];
                    y_d        = req_y[32'(pick_idx)*XY_W +: XY_W];
                    wdata_d    = req_wdata[32'(pick_idx)*DATA_W +: DATA_W];
                    grant_id_d = pick_idx;
                    rr_ptr_d   = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (mem.mem_cmd_ready) begin
                    // Writes complete on the command handshake; only reads wait for data.
                    state_d = we_q ? IDLE : WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (mem.mem_rd_valid) begin
                    rsp_data_d = mem.mem_rd_data;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready[grant_id_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            we_q       <= 1'b0;
            t_q        <= '0;
            x_q        <= '0;
            y_q        <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            we_q       <= we_d;
            t_q        <= t_d;
            x_q        <= x_d;
            y_q        <= y_d;
            wdata_q    <= wdata_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Suppress the accept pulse during reset: nothing is latched in that cycle.
    assign req_ready = (state_q == IDLE && !rst) ? pick_grant : '0;

    always_comb begin
        rsp_valid = '0;
        if (state_q == RESP) begin
            rsp_valid[grant_id_q] = 1'b1;
        end
    end

    assign rsp_data          = rsp_data_q;
    assign busy              = (state_q != IDLE);
    assign grant_id          = grant_id_q;

    assign mem.mem_cmd_valid = (state_q == ISSUE);
    assign mem.mem_rd_ready  = (state_q == WAIT_RD);
    assign mem.mem_we        = we_q;
    assign mem.mem_t         = t_q;
    assign mem.mem_x         = x_q;
    assign mem.mem_y         = y_q;
    assign mem.mem_wdata     = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed, cycle-exact bench for mem_port_arbiter with N_REQ = 4.
// The memory side is driven by hand through the interface instance.
module tb_mem_port_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned TW  = 4;
    localparam int unsigned XYW = 5;
    localparam int unsigned DW  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_we;
    logic [N*TW-1:0]   req_t;
    logic [N*XYW-1:0]  req_x;
    logic [N*XYW-1:0]  req_y;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      rsp_valid;
    logic [N-1:0]      rsp_ready;
    logic [DW-1:0]     rsp_data;
    logic              busy;
    logic [1:0]        grant_id;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter_if #(
        .T_W    (TW),
        .XY_W   (XYW),
        .DATA_W (DW)
    ) mem_bus ();

    mem_port_arbiter #(
        .N_REQ  (N),
        .T_W    (TW),
        .XY_W   (XYW),
        .DATA_W (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_t     (req_t),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .mem       (mem_bus),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 2 time units after the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic we, input logic [TW-1:0] t,
                           input logic [XYW-1:0] x, input logic [XYW-1:0] y,
                           input logic [DW-1:0] wd);
        req_we[i]               = we;
        req_t[i*TW +: TW]       = t;
        req_x[i*XYW +: XYW]     = x;
        req_y[i*XYW +: XYW]     = y;
        req_wdata[i*DW +: DW]   = wd;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, " busy"},      64'(busy), 64'd0);
        check_eq({tag, " req_ready"}, 64'(req_ready), 64'd0);
        check_eq({tag, " rsp_valid"}, 64'(rsp_valid), 64'd0);
        check_eq({tag, " cmd_valid"}, 64'(mem_bus.mem_cmd_valid), 64'd0);
        check_eq({tag, " rd_ready"},  64'(mem_bus.mem_rd_ready), 64'd0);
        check_eq({tag, " mem_we"},    64'(mem_bus.mem_we), 64'd0);
        check_eq({tag, " mem_t"},     64'(mem_bus.mem_t), 64'd0);
        check_eq({tag, " mem_x"},     64'(mem_bus.mem_x), 64'd0);
        check_eq({tag, " mem_y"},     64'(mem_bus.mem_y), 64'd0);
        check_eq({tag, " mem_wdata"}, 64'(mem_bus.mem_wdata), 64'd0);
        check_eq({tag, " rsp_data"},  64'(rsp_data), 64'd0);
        check_eq({tag, " grant_id"},  64'(grant_id), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int exp_order [6] = '{0, 1, 2, 3, 0, 1};

        req_valid = '0;
        req_we    = '0;
        req_t     = '0;
        req_x     = '0;
        req_y     = '0;
        req_wdata = '0;
        rsp_ready = 4'hF;
        mem_bus.mem_cmd_ready = 1'b1;
        mem_bus.mem_rd_valid  = 1'b0;
        mem_bus.mem_rd_data   = '0;

        step();
        step();
        rst = 1'b0;
        #1;
        check_reset_state("reset");

        // Single read: requester 2, memory answers one cycle after the command.
        set_req(2, 1'b0, 4'd3, 5'd4, 5'd5, 32'd0);
        req_valid = 4'b0100;
        #1;
        check_eq("rd c0 req_ready", 64'(req_ready), 64'b0100);
        step();
        req_valid = '0;
        #1;
        check_eq("rd c1 cmd_valid", 64'(mem_bus.mem_cmd_valid), 64'd1);
        check_eq("rd c1 we", 64'(mem_bus.mem_we), 64'd0);
        check_eq("rd c1 t", 64'(mem_bus.mem_t), 64'd3);
        check_eq("rd c1 x", 64'(mem_bus.mem_x), 64'd4);
        check_eq("rd c1 y", 64'(mem_bus.mem_y), 64'd5);
        check_eq("rd c1 grant_id", 64'(grant_id), 64'd2);
        check_eq("rd c1 rd_ready", 64'(mem_bus.mem_rd_ready), 64'd0);
        step();
        check_eq("rd c2 rd_ready", 64'(mem_bus.mem_rd_ready), 64'd1);
        mem_bus.mem_rd_valid = 1'b1;
        mem_bus.mem_rd_data  = 32'hDEAD_BEEF;
        step();
        mem_bus.mem_rd_valid = 1'b0;
        mem_bus.mem_rd_data  = '0;
        #1;
        check_eq("rd c3 rsp_valid", 64'(rsp_valid), 64'b0100);
        check_eq("rd c3 rsp_data", 64'(rsp_data), 64'hDEAD_BEEF);
        check_eq("rd c3 rd_ready", 64'(mem_bus.mem_rd_ready), 64'd0);
        step();
        check_eq("rd c4 busy", 64'(busy), 64'd0);
        check_eq("rd c4 rsp_valid", 64'(rsp_valid), 64'd0);

        // Back-to-back writes from requester 0.
        set_req(0, 1'b1, 4'd0, 5'd1, 5'd1, 32'h11);
        req_valid = 4'b0001;
        #1;
        check_eq("wr c0 req_ready", 64'(req_ready), 64'b0001);
        step();
        check_eq("wr c1 cmd_valid", 64'(mem_bus.mem_cmd_valid), 64'd1);
        check_eq("wr c1 we", 64'(mem_bus.mem_we), 64'd1);
        check_eq("wr c1 wdata", 64'(mem_bus.mem_wdata), 64'h11);
        check_eq("wr c1 x", 64'(mem_bus.mem_x), 64'd1);
        check_eq("wr c1 rsp_valid", 64'(rsp_valid), 64'd0);
        set_req(0, 1'b1, 4'd0, 5'd2, 5'd1, 32'h22);
        #1;
        check_eq("wr c1 req_ready", 64'(req_ready), 64'd0);
        step();
        check_eq("wr c2 cmd_valid", 64'(mem_bus.mem_cmd_valid), 64'd0);
        check_eq("wr c2 rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("wr c2 req_ready", 64'(req_ready), 64'b0001);
        step();
        check_eq("wr c3 cmd_valid", 64'(mem_bus.mem_cmd_valid), 64'd1);
        check_eq("wr c3 wdata", 64'(mem_bus.mem_wdata), 64'h22);
        check_eq("wr c3 x", 64'(mem_bus.mem_x), 64'd2);
        check_eq("wr c3 rsp_valid", 64'(rsp_valid), 64'd0);
        req_valid = '0;
        step();
        check_eq("wr c4 busy", 64'(busy), 64'd0);
        check_eq("wr c4 rsp_valid", 64'(rsp_valid), 64'd0);

        // Fairness: restart from rr_ptr = 0 with all four requesters writing.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(i, 1'b1, 4'(i), 5'(i), 5'(i), 32'hA0 + 32'(i));
        end
        req_valid = 4'hF;
        for (int i = 0; i < 6; i++) begin
            #1;
            check_eq($sformatf("fair %0d req_ready", i), 64'(req_ready), 64'(1) << exp_order[i]);
            step();
            check_eq($sformatf("fair %0d grant_id", i), 64'(grant_id), 64'(exp_order[i]));
            check_eq($sformatf("fair %0d wdata", i), 64'(mem_bus.mem_wdata),
                     64'h0A0 + 64'(exp_order[i]));
            step();
        end
        req_valid = '0;
        #1;

        // Backpressure: requester 1 reads; command stalled 5 cycles, response stalled 3.
        set_req(1, 1'b0, 4'd7, 5'd9, 5'd17, 32'd0);
        req_valid = 4'b0010;
        #1;
        check_eq("bp accept req_ready", 64'(req_ready), 64'b0010);
        step();
        mem_bus.mem_cmd_ready = 1'b0;
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq($sformatf("bp cmd %0d valid", k), 64'(mem_bus.mem_cmd_valid), 64'd1);
            check_eq($sformatf("bp cmd %0d t", k), 64'(mem_bus.mem_t), 64'd7);
            check_eq($sformatf("bp cmd %0d x", k), 64'(mem_bus.mem_x), 64'd9);
            check_eq($sformatf("bp cmd %0d y", k), 64'(mem_bus.mem_y), 64'd17);
            check_eq($sformatf("bp cmd %0d req_ready", k), 64'(req_ready), 64'd0);
            step();
        end
        mem_bus.mem_cmd_ready = 1'b1;
        #1;
        check_eq("bp cmd release valid", 64'(mem_bus.mem_cmd_valid), 64'd1);
        step();
        mem_bus.mem_rd_valid = 1'b1;
        mem_bus.mem_rd_data  = 32'hCAFE_F00D;
        step();
        // Keep a stray read beat on the bus to show it is not consumed in RESP.
        mem_bus.mem_rd_data = 32'h1234_5678;
        rsp_ready = 4'b1101;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq($sformatf("bp rsp %0d valid", k), 64'(rsp_valid), 64'b0010);
            check_eq($sformatf("bp rsp %0d data", k), 64'(rsp_data), 64'hCAFE_F00D);
            check_eq($sformatf("bp rsp %0d req_ready", k), 64'(req_ready), 64'd0);
            check_eq($sformatf("bp rsp %0d rd_ready", k), 64'(mem_bus.mem_rd_ready), 64'd0);
            step();
        end
        mem_bus.mem_rd_valid = 1'b0;
        rsp_ready = 4'hF;
        #1;
        check_eq("bp rsp release valid", 64'(rsp_valid), 64'b0010);
        step();
        check_eq("bp next req_ready", 64'(req_ready), 64'b0100);
        check_eq("bp rsp_data held", 64'(rsp_data), 64'hCAFE_F00D);
        req_valid = '0;
        #1;

        // Reset in WAIT_RD: requester 3 reads (pointer sits at 2).
        set_req(3, 1'b0, 4'd1, 5'd2, 5'd3, 32'd0);
        req_valid = 4'b1000;
        #1;
        check_eq("rst accept req_ready", 64'(req_ready), 64'b1000);
        step();
        req_valid = '0;
        check_eq("rst issue cmd_valid", 64'(mem_bus.mem_cmd_valid), 64'd1);
        step();
        check_eq("rst wait rd_ready", 64'(mem_bus.mem_rd_ready), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check_reset_state("midrst");
        mem_bus.mem_rd_valid = 1'b1;
        mem_bus.mem_rd_data  = 32'h5555_AAAA;
        #1;
        check_eq("midrst stray rd_ready", 64'(mem_bus.mem_rd_ready), 64'd0);
        step();
        mem_bus.mem_rd_valid = 1'b0;
        #1;
        check_eq("midrst stray rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("midrst stray busy", 64'(busy), 64'd0);
        check_eq("midrst stray rsp_data", 64'(rsp_data), 64'd0);
        req_valid = 4'hF;
        #1;
        check_eq("midrst rr_ptr zero", 64'(req_ready), 64'b0001);
        req_valid = '0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
